// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a program image from a byte stream into instruction memory and
//   holds the cpu core in reset until the image is complete and verified.
//
//   The stream is a sequence of little-endian 32-bit words:
//     word 0      : header, N = payload word count
//     words 1..N  : payload, written to BASE_ADDR + k*ADDR_STRIDE
//     final word  : checksum, sum of the payload words mod 2^32
//
// Ports
//   clock            rising-edge system clock
//   reset_n          synchronous active-low reset
//   in_data          stream byte
//   in_valid         stream byte present
//   in_ready         loader can take a byte (combinational from state)
//   reload           one-cycle pulse: restart the load, core back in reset
//   im_write_enable  one-cycle instruction memory write strobe
//   im_write_address instruction memory write address (held between writes)
//   im_write_data    instruction memory write data (held between writes)
//   core_reset_n     active-low reset to the cpu core, released on success
//   load_done        image loaded and checksum matched (sticky)
//   load_error       header too large or checksum mismatch (sticky)
//   words_loaded     count of payload words written, saturating
module imem_boot_loader #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STRIDE = 1,
  parameter int unsigned MAX_WORDS   = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_write_enable,
  output logic [ADDR_W-1:0] im_write_address,
  output logic [DATA_W-1:0] im_write_data,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ADDR_STRIDE);
  localparam logic [31:0]       MAX_N  = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          byte_idx_reg, byte_idx_next;
  // The first three bytes of a word, shifted in from the top so that the
  // earliest byte ends up in bits [7:0] when the fourth byte arrives.
  logic [DATA_W-9:0]   shift_reg, shift_next;
  logic [31:0]         remaining_reg, remaining_next;
  logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [DATA_W-1:0]   csum_reg, csum_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                core_rst_n_reg, core_rst_n_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;
  logic [15:0]         wl_reg, wl_next;

  logic                accept;
  logic                word_done;
  logic [DATA_W-1:0]   word;

  // in_ready depends on state only, never on in_valid.
  assign in_ready  = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CSUM);
  assign accept    = in_valid && in_ready;
  assign word_done = accept && (byte_idx_reg == 2'd3);
  assign word      = {in_data, shift_reg};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= HDR;
      byte_idx_reg   <= '0;
      shift_reg      <= '0;
      remaining_reg  <= '0;
      wr_ptr_reg     <= BASE;
      csum_reg       <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      core_rst_n_reg <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      wl_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      byte_idx_reg   <= byte_idx_next;
      shift_reg      <= shift_next;
      remaining_reg  <= remaining_next;
      wr_ptr_reg     <= wr_ptr_next;
      csum_reg       <= csum_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      core_rst_n_reg <= core_rst_n_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      wl_reg         <= wl_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    byte_idx_next   = byte_idx_reg;
    shift_next      = shift_reg;
    remaining_next  = remaining_reg;
    wr_ptr_next     = wr_ptr_reg;
    csum_next       = csum_reg;
    we_next         = 1'b0;
    addr_next       = addr_reg;
    data_next       = data_reg;
    core_rst_n_next = core_rst_n_reg;
    done_next       = done_reg;
    error_next      = error_reg;
    wl_next         = wl_reg;

    if (reload) begin
      // A byte or write coinciding with reload is dropped on purpose.
      state_next      = HDR;
      byte_idx_next   = '0;
      csum_next       = '0;
      wr_ptr_next     = BASE;
      core_rst_n_next = 1'b0;
      done_next       = 1'b0;
      error_next      = 1'b0;
      wl_next         = '0;
    end else if (accept) begin
      byte_idx_next = byte_idx_reg + 2'd1;
      shift_next    = {in_data, shift_reg[DATA_W-9:8]};
      if (word_done) begin
        case (state_reg)
          HDR: begin
            wr_ptr_next = BASE;
            csum_next   = '0;
            if (word > MAX_N) begin
              state_next = ERROR;
              error_next = 1'b1;
            end else if (word == '0) begin
              state_next = CSUM;
            end else begin
              state_next     = DATA;
              remaining_next = word;
            end
          end
          DATA: begin
            we_next        = 1'b1;
            addr_next      = wr_ptr_reg;
            data_next      = word;
            wr_ptr_next    = wr_ptr_reg + STRIDE;
            csum_next      = csum_reg + word;
            remaining_next = remaining_reg - 32'd1;
            if (wl_reg != 16'hFFFF) begin
              wl_next = wl_reg + 16'd1;
            end
            if (remaining_reg == 32'd1) begin
              state_next = CSUM;
            end
          end
          CSUM: begin
            if (word == csum_reg) begin
              state_next      = DONE;
              done_next       = 1'b1;
              core_rst_n_next = 1'b1;
            end else begin
              state_next = ERROR;
              error_next = 1'b1;
            end
          end
          default: begin
            state_next = state_reg;
          end
        endcase
      end
    end
  end

  assign im_write_enable  = we_reg;
  assign im_write_address = addr_reg;
  assign im_write_data    = data_reg;
  assign core_reset_n     = core_rst_n_reg;
  assign load_done        = done_reg;
  assign load_error       = error_reg;
  assign words_loaded     = wl_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader. Two instances share one stream: dut 0 uses
// the default address map, dut 1 uses BASE_ADDR=0x100 and ADDR_STRIDE=4.
// The driver pushes the writes and final status the model expects; a
// separate monitor pops them as the DUTs present writes or finish a load.
module tb_imem_boot_loader;

  localparam int MAXW = 1024;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        reload;

  logic        rdy   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] data  [2];
  logic        crn   [2];
  logic        done  [2];
  logic        err   [2];
  logic [15:0] wl    [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          k;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        done;
    logic        err;
    logic        crn;
    logic [15:0] wl;
    int          cyc;
  } st_t;

  wr_t wq0[$];
  wr_t wq1[$];
  st_t sq0[$];
  st_t sq1[$];

  logic [31:0] pay[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  imem_boot_loader dut0 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .reload(reload), .im_write_enable(we[0]),
    .im_write_address(addr[0]), .im_write_data(data[0]), .core_reset_n(crn[0]),
    .load_done(done[0]), .load_error(err[0]), .words_loaded(wl[0])
  );

  imem_boot_loader #(.BASE_ADDR(32'h100), .ADDR_STRIDE(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .reload(reload), .im_write_enable(we[1]),
    .im_write_address(addr[1]), .im_write_data(data[1]), .core_reset_n(crn[1]),
    .load_done(done[1]), .load_error(err[1]), .words_loaded(wl[1])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, i, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_write(input int i);
    wr_t         e;
    logic [31:0] ea;
    int          empty;
    empty = (i == 0) ? (wq0.size() == 0) : (wq1.size() == 0);
    tests++;
    if (empty) begin
      fails++;
      $display("FAIL unexpected_write dut%0d: addr %h data %h, expected no write", i, addr[i], data[i]);
    end else begin
      e  = (i == 0) ? wq0.pop_front() : wq1.pop_front();
      ea = (i == 0) ? 32'(e.k) : 32'h100 + 32'(e.k) * 32'd4;
      chk("write_addr", i, addr[i], ea);
      chk("write_data", i, data[i], e.d);
    end
  endtask

  task automatic mon_status(input int i);
    st_t e;
    int  empty;
    empty = (i == 0) ? (sq0.size() == 0) : (sq1.size() == 0);
    tests++;
    if (empty) begin
      fails++;
      $display("FAIL unexpected_finish dut%0d: in_ready fell, expected no completion", i);
    end else begin
      e = (i == 0) ? sq0.pop_front() : sq1.pop_front();
      chk("load_done", i, 32'(done[i]), 32'(e.done));
      chk("load_error", i, 32'(err[i]), 32'(e.err));
      chk("core_reset_n", i, 32'(crn[i]), 32'(e.crn));
      chk("words_loaded", i, 32'(wl[i]), 32'(e.wl));
      chk("finish_cycle", i, 32'(cyc), 32'(e.cyc));
      $display("[TB] dut%0d load finished: done=%b error=%b words=%0d cycle=%0d", i, done[i], err[i], wl[i], cyc);
    end
  endtask

  initial begin
    logic prev_we [2];
    logic prev_rdy[2];
    for (int i = 0; i < 2; i++) begin
      prev_we[i]  = 1'b0;
      prev_rdy[i] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (we[i] === 1'b1 && prev_we[i] === 1'b1) begin
          tests++;
          fails++;
          $display("FAIL strobe_width dut%0d: write enable high 2 cycles, expected 1", i);
        end else if (we[i] === 1'b1) begin
          mon_write(i);
        end
        if (prev_rdy[i] === 1'b1 && rdy[i] === 1'b0) mon_status(i);
        prev_we[i]  = we[i];
        prev_rdy[i] = rdy[i];
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      @(posedge clock); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    for (int j = 0; j < 4; j++) begin
      t = w >> (8 * j);
      send_byte(t[7:0], gap);
    end
  endtask

  task automatic push_status(input logic d, input logic e, input logic c, input logic [15:0] n);
    st_t s;
    s.done = d; s.err = e; s.crn = c; s.wl = n; s.cyc = cyc;
    sq0.push_back(s);
    sq1.push_back(s);
  endtask

  function automatic logic [31:0] pay_sum(input int n);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s += pay[k];
    return s;
  endfunction

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (wq0.size() + wq1.size() + sq0.size() + sq1.size() == 0) break;
      @(posedge clock); #1;
    end
    chk("queues_drained", 0, 32'(wq0.size() + wq1.size() + sq0.size() + sq1.size()), 32'd0);
  endtask

  // Model: header over MAX_WORDS fails at the header; otherwise every
  // payload word is written at index k and the load succeeds only if the
  // checksum field equals the 32-bit sum of the payload.
  task automatic run_load(input logic [31:0] hdr, input logic [31:0] cs, input int gap);
    wr_t w;
    logic ok;
    if (hdr > 32'(MAXW)) begin
      send_word(hdr, gap);
      push_status(1'b0, 1'b1, 1'b0, 16'd0);
    end else begin
      for (int k = 0; k < int'(hdr); k++) begin
        w.k = k;
        w.d = pay[k];
        wq0.push_back(w);
        wq1.push_back(w);
      end
      ok = (cs == pay_sum(int'(hdr)));
      send_word(hdr, gap);
      for (int k = 0; k < int'(hdr); k++) send_word(pay[k], gap);
      send_word(cs, gap);
      push_status(ok, !ok, ok, hdr[15:0]);
    end
    drain();
  endtask

  task automatic chk_idle(input string name, input logic exp_done, input logic exp_err,
                          input logic exp_crn, input logic [15:0] exp_wl, input logic exp_rdy);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_done"}, i, 32'(done[i]), 32'(exp_done));
      chk({name, "_error"}, i, 32'(err[i]), 32'(exp_err));
      chk({name, "_core_reset_n"}, i, 32'(crn[i]), 32'(exp_crn));
      chk({name, "_words"}, i, 32'(wl[i]), 32'(exp_wl));
      chk({name, "_in_ready"}, i, 32'(rdy[i]), 32'(exp_rdy));
      chk({name, "_we"}, i, 32'(we[i]), 32'd0);
    end
  endtask

  task automatic do_reload();
    reload   = 1'b1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reload = 1'b0;
    chk_idle("after_reload", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic set_two_word();
    pay.delete();
    pay.push_back(32'h11223344);
    pay.push_back(32'hAABBCCDD);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] cs;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    reload   = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk_idle("reset", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("reset_addr", i, addr[i], 32'd0);
      chk("reset_data", i, data[i], 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Two-word load, then ignored traffic while DONE is held.
    set_two_word();
    run_load(32'd2, 32'hBBDE0021, 0);
    $display("[TB] scenario two_word done");
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (5) begin @(posedge clock); #1; end
    in_valid = 1'b0;
    chk_idle("sticky_done", 1'b1, 1'b0, 1'b1, 16'd2, 1'b0);

    // Empty image.
    do_reload();
    run_load(32'd0, 32'd0, 0);
    $display("[TB] scenario empty done");

    // Bad checksum.
    do_reload();
    set_two_word();
    run_load(32'd2, 32'hBBDE0022, 0);
    $display("[TB] scenario bad_checksum done");
    repeat (3) begin @(posedge clock); #1; end
    chk_idle("sticky_error", 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);

    // Oversize header.
    do_reload();
    run_load(32'(MAXW + 1), 32'd0, 0);
    $display("[TB] scenario oversize done");

    // Gaps in in_valid.
    do_reload();
    set_two_word();
    run_load(32'd2, 32'hBBDE0021, 5);
    $display("[TB] scenario gaps done");

    // Reload coincident with the last byte of payload word 0.
    do_reload();
    send_word(32'd2, 0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    send_byte(8'h22, 0);
    in_data  = 8'h11;
    in_valid = 1'b1;
    reload   = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    reload   = 1'b0;
    chk_idle("reload_priority", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    set_two_word();
    run_load(32'd2, 32'hBBDE0021, 0);
    $display("[TB] scenario reload_restart done");

    // Reset from DONE.
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_idle("reset_from_done", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("reset_from_done_addr", i, addr[i], 32'd0);
    end

    // Largest accepted image.
    do_reload();
    pay.delete();
    for (int k = 0; k < MAXW; k++) pay.push_back($urandom);
    run_load(32'(MAXW), pay_sum(MAXW), 0);
    $display("[TB] scenario max_words done");

    // Randomized loads.
    for (int t = 0; t < 20; t++) begin
      do_reload();
      n = int'($urandom_range(0, 6));
      pay.delete();
      for (int k = 0; k < n; k++) pay.push_back($urandom);
      cs = pay_sum(n);
      if ($urandom_range(0, 3) == 0) cs = cs ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) begin
        run_load(32'(MAXW + 1) + 32'($urandom_range(0, 1000)), cs, 3);
      end else begin
        run_load(32'(n), cs, int'($urandom_range(0, 3)));
      end
      $display("[TB] random load %0d: N=%0d", t, n);
    end

    repeat (4) begin @(posedge clock); #1; end
    chk("final_queues_empty", 0, 32'(wq0.size() + wq1.size() + sq0.size() + sq1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the instruction memory and the cpu core. Receives a program image as a byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit words and writes them into instruction memory through the im_write_* port.
- Holds the core in reset until the whole image is loaded and its checksum has been verified.
- Replaces file-based loadMem preloading with a synthesizable load path.

Parameters:
ADDR_W, 32, width of instruction memory address (matches ADDRESS_SIZE)
DATA_W, 32, instruction word width (matches DATA_SIZE); fixed at 32
BASE_ADDR, 0, address of the first payload word
ADDR_STRIDE, 1, address increment per payload word
MAX_WORDS, 1024, largest accepted payload word count

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
in_data  in  8  stream byte
in_valid  in  1  byte present
in_ready  out  1  loader accepts byte; transfer happens when in_valid and in_ready are both high at the rising edge
reload  in  1  single-cycle pulse: restart the load, put the core back in reset
im_write_enable  out  1  instruction memory write strobe
im_write_address  out  ADDR_W  write address
im_write_data  out  32  write data
core_reset_n  out  1  reset to the cpu core, active low
load_done  out  1  image loaded and checksum matched
load_error  out  1  header or checksum fault
words_loaded  out  16  count of payload words written

Behaviour:
- Reset: reset_n is synchronous and active-low. While reset_n=0 at a rising edge, all registered outputs take their reset values:
  - im_write_enable=0, im_write_address=0, im_write_data=0
  - core_reset_n=0, load_done=0, load_error=0, words_loaded=0
  - state=HDR, byte index=0, checksum accumulator=0
- Stream format: all words are little-endian, 4 bytes each (first byte = bits[7:0]).
  - Word 0 is the header: N = payload word count.
  - Words 1..N are the payload.
  - The final word is the checksum: sum of the payload words mod 2^32.
- States: HDR, DATA, CSUM, DONE, ERROR.
- in_ready = 1 in HDR, DATA and CSUM; 0 in DONE and ERROR. in_ready is combinational from state only, with no dependency on in_valid.
- A 2-bit byte index counts accepted bytes within the current word. Gaps in in_valid of any length are tolerated with no effect on state.
- HDR, on the edge that accepts the 4th byte:
  - N > MAX_WORDS -> ERROR, load_error=1.
  - N = 0 -> CSUM.
  - Otherwise -> DATA, with the remaining-word count set to N.
- DATA, on the edge that accepts the 4th byte of a word:
  - im_write_enable=1 for exactly one cycle.
  - im_write_address = BASE_ADDR + k*ADDR_STRIDE, where k is the 0-based word index.
  - im_write_data = the assembled word; the checksum accumulator is updated.
  - words_loaded increments (saturating at 16 bits).
  - After the Nth word -> CSUM.
- Write strobe and back-pressure: im_write_enable deasserts at the next edge. Address and data hold their values until the next write. At most one write occurs per 4 accepted bytes, so no back-pressure from memory is needed.
- CSUM, on the edge that accepts the 4th byte:
  - Match -> DONE; load_done=1 and core_reset_n=1 on that same edge.
  - Mismatch -> ERROR; load_error=1, core_reset_n stays 0.
- DONE and ERROR are sticky: they persist until reload or reset_n.
- reload=1 at an edge, from any state:
  - Go to HDR; clear the byte index, accumulator, load_done, load_error and words_loaded.
  - core_reset_n=0 and im_write_enable=0 on that edge.
  - reload has priority over a simultaneous byte transfer; that byte is discarded.
  - reload has priority over a write that would have fired on the same edge; no write occurs.
- reset_n has priority over reload.
- reset_n=0 mid-load aborts the load. Memory contents already written are not cleared.
- core_reset_n never glitches high before DONE; it is a registered output.
- Arithmetic: the checksum uses 32-bit wrap-around addition. The address uses ADDR_W-bit wrap-around.

Test Plan:
1. Two-word load:
   - Stimulus: stream 02 00 00 00 | 44 33 22 11 | DD CC BB AA | 21 00 DE BB with in_valid held high.
   - Required response: writes (0, 0x11223344) and (1, 0xAABBCCDD), each a one-cycle strobe; then load_done=1 and core_reset_n=1 on the 16th byte edge; words_loaded=2; in_ready=0 afterwards.
2. Empty image:
   - Stimulus: 00 00 00 00 | 00 00 00 00.
   - Required response: no im_write_enable pulse; load_done=1 and core_reset_n=1 after byte 8.
3. Bad checksum:
   - Stimulus: as scenario 1, but the checksum is 22 00 DE BB.
   - Required response: both writes occur; load_error=1; core_reset_n stays 0; words_loaded=2; in_ready=0.
4. Oversize header:
   - Stimulus: N = MAX_WORDS+1 (01 04 00 00 at the default MAX_WORDS).
   - Required response: load_error=1 on the 4th byte edge; no writes.
5. Gaps, BASE_ADDR and ADDR_STRIDE:
   - Stimulus: scenario 1 with random in_valid gaps of 0-5 cycles, BASE_ADDR=0x100, ADDR_STRIDE=4.
   - Required response: writes land at 0x100 and 0x104 with the same data; completion is otherwise identical to scenario 1.
6. Restart and priority:
   - Stimulus: reload pulsed coincident with the 4th byte of payload word 0, then the full scenario 1 stream resent.
   - Required response: no write on the reload edge; the resent stream completes exactly as scenario 1.
   - Stimulus: reset_n=0 for one cycle from DONE.
   - Required response: core_reset_n=0, load_done=0, state=HDR.
